// File: rtl/calc_pkg.sv
// Shared definitions for the keypad front end and the gencon calculator controller.
package calc_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b100;

  // Encoding is the matrix position 4*row+col, so a scanned code casts directly.
  typedef enum logic [3:0] {
    KEY_1    = 4'd0,  KEY_2   = 4'd1,  KEY_3   = 4'd2,  KEY_ADD  = 4'd3,
    KEY_4    = 4'd4,  KEY_5   = 4'd5,  KEY_6   = 4'd6,  KEY_SUB  = 4'd7,
    KEY_7    = 4'd8,  KEY_8   = 4'd9,  KEY_9   = 4'd10, KEY_MUL  = 4'd11,
    KEY_CLR  = 4'd12, KEY_0   = 4'd13, KEY_EQ  = 4'd14, KEY_NONE = 4'd15
  } key_code_e;

  typedef enum logic [2:0] {
    ST_SCAN, ST_DEBOUNCE, ST_EMIT, ST_STROBE, ST_RELEASE
  } scan_state_e;

  function automatic logic is_digit(input key_code_e k);
    case (k)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: is_digit = 1'b1;
      default:                           is_digit = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] key_digit(input key_code_e k);
    case (k)
      KEY_1:   key_digit = 4'd1;
      KEY_2:   key_digit = 4'd2;
      KEY_3:   key_digit = 4'd3;
      KEY_4:   key_digit = 4'd4;
      KEY_5:   key_digit = 4'd5;
      KEY_6:   key_digit = 4'd6;
      KEY_7:   key_digit = 4'd7;
      KEY_8:   key_digit = 4'd8;
      KEY_9:   key_digit = 4'd9;
      default: key_digit = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Four-bit two-flop synchronizer; resets to all ones (idle, pulled-up rows).
module sync_2ff (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner/debouncer that turns accepted presses into gencon's
// digit strobe, one-hot operator level and equal request.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  input  logic       complete,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DBC_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CNT - 1);

  scan_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DBC_W-1:0] dbc_q, dbc_d;
  logic [3:0]       col_q, col_d;
  key_code_e        code_q, code_d;
  logic [3:0]       key_q, key_d;
  logic [2:0]       op_q, op_d;
  logic             eq_q, eq_d;

  logic [3:0] rows_sync;
  logic       sample;
  logic       any_low;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  key_code_e  samp_code;

  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(nRST),
    .d    (row_in),
    .q    (rows_sync)
  );

  assign sample  = (div_q == DIV_LAST);
  assign any_low = ~&rows_sync;

  // Lowest row index wins when several rows are pulled low together.
  always_comb begin
    col_idx = 2'd0;
    case (col_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_sync[r]) row_idx = 2'(r);
    end
    samp_code = key_code_e'({row_idx, col_idx});
  end

  always_comb begin
    state_d = state_q;
    div_d   = sample ? '0 : div_q + 1'b1;
    dbc_d   = dbc_q;
    col_d   = col_q;
    code_d  = code_q;
    key_d   = key_q;
    op_d    = op_q;
    eq_d    = eq_q;

    // Handshake close first so a key effect in the same cycle can still apply.
    if (eq_q && complete) begin
      eq_d = 1'b0;
      op_d = OP_NONE;
    end

    case (state_q)
      ST_SCAN: begin
        if (sample) begin
          if (any_low) begin
            code_d  = samp_code;
            dbc_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (any_low && (samp_code == code_q)) begin
            if (dbc_q == DBC_LAST) begin
              dbc_d   = '0;
              state_d = ST_EMIT;
              if (is_digit(code_q)) key_d = key_digit(code_q);
            end else begin
              dbc_d = dbc_q + 1'b1;
            end
          end else begin
            dbc_d   = '0;
            state_d = ST_SCAN;
          end
        end
      end
      ST_EMIT: begin
        case (code_q)
          KEY_ADD: op_d = OP_ADD;
          KEY_SUB: op_d = OP_SUB;
          KEY_MUL: op_d = OP_MUL;
          KEY_EQ:  if (op_q != OP_NONE && !eq_q) eq_d = 1'b1;
          KEY_CLR: begin
            op_d = OP_NONE;
            eq_d = 1'b0;
          end
          default: ;
        endcase
        state_d = is_digit(code_q) ? ST_STROBE : ST_RELEASE;
        dbc_d   = '0;
      end
      ST_STROBE: begin
        dbc_d   = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (sample) begin
          if (any_low) begin
            dbc_d = '0;
          end else if (dbc_q == DBC_LAST) begin
            dbc_d   = '0;
            state_d = ST_SCAN;
          end else begin
            dbc_d = dbc_q + 1'b1;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_SCAN;
      div_q   <= '0;
      dbc_q   <= '0;
      col_q   <= 4'b1110;
      code_q  <= KEY_NONE;
      key_q   <= 4'd0;
      op_q    <= OP_NONE;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dbc_q   <= dbc_d;
      col_q   <= col_d;
      code_q  <= code_d;
      key_q   <= key_d;
      op_q    <= op_d;
      eq_q    <= eq_d;
    end
  end

  assign col_out        = col_q;
  assign keypad_input   = key_q;
  assign read_input     = (state_q == ST_STROBE);
  assign operator_input = op_q;
  assign equal_input    = eq_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a key-matrix model and a gencon complete responder.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       complete = 1'b0;
  logic [3:0] keypad_input;
  logic       read_input;
  logic [2:0] operator_input;
  logic       equal_input;

  int total = 0;
  int bad   = 0;

  logic       key_down = 1'b0;
  logic [1:0] key_row  = 2'd0;
  logic [1:0] key_col  = 2'd0;
  logic       cmpl_en  = 1'b0;
  int         eq_age   = 0;

  logic [3:0] kp_prev = 4'd0;
  logic [3:0] strobes[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk           (clk),
    .nRST          (nRST),
    .row_in        (row_in),
    .col_out       (col_out),
    .complete      (complete),
    .keypad_input  (keypad_input),
    .read_input    (read_input),
    .operator_input(operator_input),
    .equal_input   (equal_input)
  );

  always #5 clk = ~clk;

  // Pressed switch shorts its row to the column being driven low.
  always_comb begin
    row_in = 4'hF;
    if (key_down && !col_out[key_col]) row_in[key_row] = 1'b0;
  end

  // gencon stand-in: raise complete on the 5th cycle equal_input is seen high.
  always @(negedge clk) begin
    if (cmpl_en && equal_input) begin
      eq_age   = eq_age + 1;
      complete = (eq_age == 5);
    end else begin
      eq_age   = 0;
      complete = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (read_input) strobes.push_back(kp_prev);
    kp_prev = keypad_input;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic key_on(input int code);
    key_row  = 2'(code >> 2);
    key_col  = 2'(code & 3);
    key_down = 1'b1;
  endtask

  task automatic key_off();
    key_down = 1'b0;
  endtask

  task automatic press(input int code);
    key_on(code);
    repeat (50) step();
    key_off();
    repeat (40) step();
  endtask

  task automatic wait_col(input logic [3:0] c, input string tag);
    int n = 0;
    while (col_out == c && n < 40) begin step(); n++; end
    while (col_out != c && n < 40) begin step(); n++; end
    if (n >= 40) chk(tag, 32'(col_out), 32'(c));
  endtask

  task automatic chk_strobes(input string tag, input logic [3:0] exp[$]);
    chk({tag, "_cnt"}, 32'(strobes.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < strobes.size(); i++)
      chk($sformatf("%s_val%0d", tag, i), 32'(strobes[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [3:0] col_exp[4];
    int n;
    col_exp[0] = 4'b1110; col_exp[1] = 4'b1101;
    col_exp[2] = 4'b1011; col_exp[3] = 4'b0111;

    // 1: reset values and idle column rotation
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(col_out), 32'hE);
    chk("rst_key", 32'(keypad_input), 32'h0);
    chk("rst_read", 32'(read_input), 32'h0);
    chk("rst_op", 32'(operator_input), 32'h0);
    chk("rst_eq", 32'(equal_input), 32'h0);
    nRST = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rot%0d", i), 32'(col_out), 32'(col_exp[i / 4]));
      step();
    end

    // 2: same key twice, released between presses
    strobes.delete();
    press(1);
    press(1);
    chk_strobes("two_presses", '{4'd2, 4'd2});

    // 3: short glitch on row0/col0 must not be accepted
    strobes.delete();
    wait_col(4'b1110, "glitch_col_to");
    key_on(0);
    repeat (6) step();
    key_off();
    repeat (40) step();
    chk("glitch_cnt", 32'(strobes.size()), 32'd0);
    chk("glitch_key", 32'(keypad_input), 32'd2);
    chk("glitch_op", 32'(operator_input), 32'd0);

    // 4: 1 2 + 3 1 = with complete handshake
    strobes.delete();
    cmpl_en = 1'b1;
    press(0);
    press(1);
    press(3);
    chk("seq_op_add", 32'(operator_input), 32'b001);
    press(2);
    press(0);
    chk_strobes("seq", '{4'd1, 4'd2, 4'd3, 4'd1});
    key_on(14);
    n = 0;
    while (!equal_input && n < 80) begin step(); n++; end
    chk("seq_eq_set", 32'(equal_input), 32'd1);
    chk("seq_eq_op", 32'(operator_input), 32'b001);
    n = 0;
    while (!complete && n < 20) begin step(); n++; end
    chk("seq_cmpl_seen", 32'(complete), 32'd1);
    chk("seq_eq_hold", 32'(equal_input), 32'd1);
    step();
    chk("seq_eq_clr", 32'(equal_input), 32'd0);
    chk("seq_op_clr", 32'(operator_input), 32'd0);
    key_off();
    repeat (40) step();
    cmpl_en = 1'b0;

    // 5: = without operator, - then C, spare key
    strobes.delete();
    press(14);
    chk("noop_eq", 32'(equal_input), 32'd0);
    press(7);
    chk("sub_op", 32'(operator_input), 32'b010);
    press(12);
    chk("clr_op", 32'(operator_input), 32'b000);
    press(11);
    chk("mul_op", 32'(operator_input), 32'b100);
    press(15);
    chk("spare_op", 32'(operator_input), 32'b100);
    chk("spare_eq", 32'(equal_input), 32'd0);
    chk("spare_cnt", 32'(strobes.size()), 32'd0);

    // 6: async reset with equal pending while debouncing a digit
    press(14);
    chk("pend_eq", 32'(equal_input), 32'd1);
    key_on(5);
    wait_col(4'b1101, "pend_col_to");
    repeat (6) step();
    chk("pend_frozen", 32'(col_out), 32'b1101);
    #2 nRST = 1'b0;
    #1;
    chk("arst_col", 32'(col_out), 32'hE);
    chk("arst_key", 32'(keypad_input), 32'h0);
    chk("arst_read", 32'(read_input), 32'h0);
    chk("arst_op", 32'(operator_input), 32'h0);
    chk("arst_eq", 32'(equal_input), 32'h0);
    key_off();
    step();
    nRST = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
